// File: rtl/plant_model.sv
// rtl/plant_model.sv - first-order lag plant with dead time and additive disturbance
module plant_model #(
  parameter int TICK_DIV = 4,
  parameter int DELAY    = 0,
  parameter int SHIFT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] control_in,
  input  logic [7:0] disturbance,
  output logic [7:0] feedback,
  output logic       sample_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_PUBLISH = 2'd2;
  localparam int         DL        = (DELAY == 0) ? 1 : DELAY;
  localparam logic [7:0] CNT_LAST  = 8'(TICK_DIV - 1);

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        y_q, y_d;
  logic [7:0]         dly_q [DL];
  logic [7:0]         dly_d [DL];
  logic [7:0]         feedback_q, feedback_d;
  logic               sample_valid_q, sample_valid_d;
  logic               tick;
  logic [7:0]         u_eff;
  logic signed [16:0] diff, step;
  logic [8:0]         m;
  logic signed [9:0]  s;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = (en && !tick) ? cnt_q + 8'd1 : 8'd0;

    case (state_q)
      S_IDLE, S_COUNT, S_PUBLISH: state_d = !en ? S_IDLE : (tick ? S_PUBLISH : S_COUNT);
      default:                    state_d = S_IDLE;
    endcase

    // With no dead time the live input feeds the lag directly; the unused entry is harmless.
    u_eff = (DELAY == 0) ? control_in : dly_q[DL-1];
    diff  = $signed({1'b0, u_eff, 8'h00}) - $signed({1'b0, y_q});
    step  = diff >>> SHIFT;

    y_d   = y_q;
    dly_d = dly_q;
    if (tick) begin
      y_d      = y_q + 16'(step);
      dly_d[0] = control_in;
      for (int i = 1; i < DL; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    m = 9'(({1'b0, y_q} + 17'h00080) >> 8);
    s = $signed({1'b0, m}) + $signed({{2{disturbance[7]}}, disturbance});

    feedback_d     = feedback_q;
    sample_valid_d = (state_q == S_PUBLISH);
    if (state_q == S_PUBLISH) begin
      if (s < 10'sd0)        feedback_d = 8'd0;
      else if (s > 10'sd255) feedback_d = 8'd255;
      else                   feedback_d = s[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      y_q            <= 16'd0;
      feedback_q     <= 8'd0;
      sample_valid_q <= 1'b0;
      for (int i = 0; i < DL; i++) begin
        dly_q[i] <= 8'd0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      y_q            <= y_d;
      feedback_q     <= feedback_d;
      sample_valid_q <= sample_valid_d;
      dly_q          <= dly_d;
    end
  end

  assign feedback     = feedback_q;
  assign sample_valid = sample_valid_q;

endmodule
